// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared forwarding encodings and MDU state type for the hazard unit
package pipe_pkg;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  typedef enum logic {MDU_IDLE, MDU_BUSY} mdu_state_e;

endpackage

// File: rtl/mdu_lat_ctr.sv
// rtl/mdu_lat_ctr.sv - MDU latency FSM: counts down the multi-cycle op and flags its completion
module mdu_lat_ctr
  import pipe_pkg::*;
#(
  parameter int MDU_LAT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic abort,
  output logic stall,
  output logic busy,
  output logic done
);

  localparam int CW = $clog2(MDU_LAT);
  localparam logic [CW-1:0] CNT_LOAD = CW'(MDU_LAT - 1);

  mdu_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (rst || abort) begin
      state_d = MDU_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        MDU_IDLE: begin
          if (start) begin
            state_d = MDU_BUSY;
            cnt_d   = CNT_LOAD;
          end
        end
        MDU_BUSY: begin
          // start is still high on the done cycle; returning to IDLE prevents a re-launch
          if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
          else             state_d = MDU_IDLE;
        end
        default: begin
          state_d = MDU_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MDU_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign stall = ((state_q == MDU_IDLE) && start) || ((state_q == MDU_BUSY) && (cnt_q != '0));
  assign busy  = (state_q == MDU_BUSY) && !rst;
  assign done  = (state_q == MDU_BUSY) && (cnt_q == '0) && !rst && !abort;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - forwarding selects, interlocks and per-stage stall/flush for the 5-stage core
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int MDU_LAT  = 4,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rs_D,
  input  logic [REG_AW-1:0] rt_D,
  input  logic              branch2_D,
  input  logic              branch1_D,
  input  logic              jr_D,
  input  logic [REG_AW-1:0] rs_E,
  input  logic [REG_AW-1:0] rt_E,
  input  logic [REG_AW-1:0] wreg_E,
  input  logic              regwrite_E,
  input  logic              memread_E,
  input  logic              mdu_start_E,
  input  logic [REG_AW-1:0] wreg_M,
  input  logic              regwrite_M,
  input  logic              memread_M,
  input  logic              except_M,
  input  logic [REG_AW-1:0] wreg_W,
  input  logic              regwrite_W,
  output logic              fwd_a_D,
  output logic              fwd_b_D,
  output logic [1:0]        fwd_a_E,
  output logic [1:0]        fwd_b_E,
  output logic              stall_F,
  output logic              stall_D,
  output logic              stall_E,
  output logic              stall_M,
  output logic              stall_W,
  output logic              flush_F,
  output logic              flush_D,
  output logic              flush_E,
  output logic              flush_M,
  output logic              flush_W,
  output logic              mdu_busy,
  output logic              mdu_done
);

  // With ZERO_REG set, $0 is hard-wired and never a real dependency
  function automatic logic reg_match(input logic [REG_AW-1:0] a, input logic [REG_AW-1:0] b);
    return (a == b) && ((ZERO_REG == 0) || (a != '0));
  endfunction

  function automatic logic [1:0] fwd_sel_E(input logic [REG_AW-1:0] src);
    if (regwrite_M && reg_match(src, wreg_M))      return FWD_M;
    else if (regwrite_W && reg_match(src, wreg_W)) return FWD_W;
    else                                           return FWD_RF;
  endfunction

  logic mdu_stall;
  logic hz;
  logic hz_load_use, hz_branch2, hz_branch1;
  logic kill;

  mdu_lat_ctr #(.MDU_LAT(MDU_LAT)) u_mdu (
    .clk   (clk),
    .rst   (rst),
    .start (mdu_start_E),
    .abort (except_M),
    .stall (mdu_stall),
    .busy  (mdu_busy),
    .done  (mdu_done)
  );

  assign fwd_a_D = regwrite_M && reg_match(rs_D, wreg_M);
  assign fwd_b_D = regwrite_M && reg_match(rt_D, wreg_M);
  assign fwd_a_E = fwd_sel_E(rs_E);
  assign fwd_b_E = fwd_sel_E(rt_E);

  assign hz_load_use = memread_E && (reg_match(rs_D, wreg_E) || reg_match(rt_D, wreg_E));
  assign hz_branch2  = branch2_D &&
                       ((regwrite_E && (reg_match(rs_D, wreg_E) || reg_match(rt_D, wreg_E))) ||
                        (memread_M  && (reg_match(rs_D, wreg_M) || reg_match(rt_D, wreg_M))));
  assign hz_branch1  = (branch1_D || jr_D) &&
                       ((regwrite_E && reg_match(rs_D, wreg_E)) ||
                        (memread_M  && reg_match(rs_D, wreg_M)));
  assign hz = hz_load_use || hz_branch2 || hz_branch1;

  // Reset and exceptions both drain the whole pipe and release every hold
  assign kill = rst || except_M;

  assign stall_F = !kill && (mdu_stall || hz);
  assign stall_D = !kill && (mdu_stall || hz);
  assign stall_E = !kill && mdu_stall;
  assign stall_M = !kill && mdu_stall;
  assign stall_W = !kill && mdu_stall;

  assign flush_F = kill;
  assign flush_D = kill;
  // A hazard behind a held MDU op keeps E frozen rather than bubbling it
  assign flush_E = kill || (!mdu_stall && hz);
  assign flush_M = kill;
  assign flush_W = kill;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed and random checks of pipe_hazard_ctrl against a rule-level model
module tb_pipe_hazard_ctrl;

  localparam int REG_AW  = 5;
  localparam int MDU_LAT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [REG_AW-1:0] rs_D, rt_D, rs_E, rt_E, wreg_E, wreg_M, wreg_W;
  logic              branch2_D, branch1_D, jr_D;
  logic              regwrite_E, memread_E, mdu_start_E;
  logic              regwrite_M, memread_M, except_M, regwrite_W;
  logic              fwd_a_D, fwd_b_D;
  logic [1:0]        fwd_a_E, fwd_b_E;
  logic              stall_F, stall_D, stall_E, stall_M, stall_W;
  logic              flush_F, flush_D, flush_E, flush_M, flush_W;
  logic              mdu_busy, mdu_done;

  pipe_hazard_ctrl #(.REG_AW(REG_AW), .MDU_LAT(MDU_LAT), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst),
    .rs_D(rs_D), .rt_D(rt_D), .branch2_D(branch2_D), .branch1_D(branch1_D), .jr_D(jr_D),
    .rs_E(rs_E), .rt_E(rt_E), .wreg_E(wreg_E),
    .regwrite_E(regwrite_E), .memread_E(memread_E), .mdu_start_E(mdu_start_E),
    .wreg_M(wreg_M), .regwrite_M(regwrite_M), .memread_M(memread_M), .except_M(except_M),
    .wreg_W(wreg_W), .regwrite_W(regwrite_W),
    .fwd_a_D(fwd_a_D), .fwd_b_D(fwd_b_D), .fwd_a_E(fwd_a_E), .fwd_b_E(fwd_b_E),
    .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E), .stall_M(stall_M), .stall_W(stall_W),
    .flush_F(flush_F), .flush_D(flush_D), .flush_E(flush_E), .flush_M(flush_M), .flush_W(flush_W),
    .mdu_busy(mdu_busy), .mdu_done(mdu_done)
  );

  int checks = 0;
  int failures = 0;

  // Model of the MDU: whether an op is in flight and how many edges since it launched
  bit m_active = 0;
  int m_age = 0;

  function automatic bit mm(input int a, input int b);
    return (a == b) && (a != 0);
  endfunction

  function automatic logic [1:0] exp_fwd(input int src);
    if (regwrite_M && mm(src, wreg_M)) return 2'b10;
    if (regwrite_W && mm(src, wreg_W)) return 2'b01;
    return 2'b00;
  endfunction

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check(input string tag);
    bit hz, ms, kill;
    logic [4:0] es, ef;
    #1;
    hz = (memread_E && (mm(rs_D, wreg_E) || mm(rt_D, wreg_E)))
      || (branch2_D && ((regwrite_E && (mm(rs_D, wreg_E) || mm(rt_D, wreg_E)))
                     || (memread_M && (mm(rs_D, wreg_M) || mm(rt_D, wreg_M)))))
      || ((branch1_D || jr_D) && ((regwrite_E && mm(rs_D, wreg_E)) || (memread_M && mm(rs_D, wreg_M))));
    ms = m_active ? (m_age < MDU_LAT) : mdu_start_E;
    kill = rst || except_M;
    es = kill ? 5'b00000 : {ms | hz, ms | hz, ms, ms, ms};
    ef = kill ? 5'b11111 : {2'b00, !ms && hz, 2'b00};
    chk({tag, ".fwdD"}, {6'd0, fwd_a_D, fwd_b_D},
        {6'd0, regwrite_M && mm(rs_D, wreg_M), regwrite_M && mm(rt_D, wreg_M)});
    chk({tag, ".fwdE"}, {4'd0, fwd_a_E, fwd_b_E}, {4'd0, exp_fwd(rs_E), exp_fwd(rt_E)});
    chk({tag, ".stall"}, {3'd0, stall_F, stall_D, stall_E, stall_M, stall_W}, {3'd0, es});
    chk({tag, ".flush"}, {3'd0, flush_F, flush_D, flush_E, flush_M, flush_W}, {3'd0, ef});
    chk({tag, ".busy"}, {7'd0, mdu_busy}, {7'd0, m_active && !rst});
    chk({tag, ".done"}, {7'd0, mdu_done}, {7'd0, m_active && (m_age == MDU_LAT) && !kill});
  endtask

  task automatic tick();
    if (rst || except_M) m_active = 0;
    else if (!m_active) begin
      if (mdu_start_E) begin m_active = 1; m_age = 1; end
    end else if (m_age == MDU_LAT) m_active = 0;
    else m_age++;
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    {rs_D, rt_D, rs_E, rt_E, wreg_E, wreg_M, wreg_W} = '0;
    {branch2_D, branch1_D, jr_D, regwrite_E, memread_E, mdu_start_E} = '0;
    {regwrite_M, memread_M, except_M, regwrite_W} = '0;
  endtask

  initial begin
    idle();
    rst = 1;
    @(posedge clk); #2;
    check("rst0"); chk("rst_flushE", {7'd0, flush_E}, 8'd1); tick();
    check("rst1"); tick();
    rst = 0;

    // Forwarding priority and $0
    regwrite_M = 1; wreg_M = 5; regwrite_W = 1; wreg_W = 5; rs_E = 5;
    check("fwdM"); chk("fwdM_a", {6'd0, fwd_a_E}, 8'h2); tick();
    regwrite_M = 0;
    check("fwdW"); chk("fwdW_a", {6'd0, fwd_a_E}, 8'h1); tick();
    regwrite_M = 1; wreg_M = 0; rs_E = 0; wreg_W = 0;
    check("fwd0"); chk("fwd0_a", {6'd0, fwd_a_E}, 8'h0); tick();
    idle();

    // Load-use: one bubble, then forward from M
    memread_E = 1; regwrite_E = 1; wreg_E = 3; rt_D = 3;
    check("lu0"); chk("lu_stallF", {7'd0, stall_F}, 8'd1); chk("lu_flushE", {7'd0, flush_E}, 8'd1); tick();
    memread_E = 0; regwrite_E = 0; memread_M = 1; regwrite_M = 1; wreg_M = 3; rt_E = 3; rt_D = 0;
    check("lu1"); chk("lu_fwdb", {6'd0, fwd_b_E}, 8'h2); chk("lu_nostall", {7'd0, stall_D}, 8'd0); tick();
    idle();

    // Branch against a load in M, then against an ALU writer in E
    branch2_D = 1; rs_D = 4; rt_D = 7; memread_M = 1; regwrite_M = 1; wreg_M = 7;
    check("br0"); chk("br_ld_stall", {7'd0, stall_D}, 8'd1); tick();
    memread_M = 0; regwrite_M = 0; wreg_M = 0; regwrite_W = 1; wreg_W = 7;
    check("br1"); chk("br_fwdb0", {7'd0, fwd_b_D}, 8'd0); chk("br1_nostall", {7'd0, stall_D}, 8'd0); tick();
    regwrite_W = 0; regwrite_E = 1; wreg_E = 7;
    check("br2"); chk("br_alu_stall", {7'd0, stall_D}, 8'd1); tick();
    regwrite_E = 0; regwrite_M = 1; wreg_M = 7;
    check("br3"); chk("br_fwdb1", {7'd0, fwd_b_D}, 8'd1); chk("br3_nostall", {7'd0, stall_D}, 8'd0); tick();
    idle();

    // MDU timing, back-to-back start, abort with cnt==2
    mdu_start_E = 1;
    for (int i = 0; i < 5; i++) begin
      check("div");
      chk("div_stallE", {7'd0, stall_E}, {7'd0, i < 4});
      chk("div_done", {7'd0, mdu_done}, {7'd0, i == 4});
      tick();
    end
    check("b2b0"); chk("b2b_stallE", {7'd0, stall_E}, 8'd1); chk("b2b_busy0", {7'd0, mdu_busy}, 8'd0); tick();
    check("b2b1"); chk("b2b_busy1", {7'd0, mdu_busy}, 8'd1); tick();
    except_M = 1;
    check("abort"); chk("abort_flushW", {7'd0, flush_W}, 8'd1); chk("abort_stallE", {7'd0, stall_E}, 8'd0); tick();
    except_M = 0; mdu_start_E = 0;
    check("abort1"); chk("abort_busy", {7'd0, mdu_busy}, 8'd0); chk("abort_done", {7'd0, mdu_done}, 8'd0); tick();

    // Reset in the middle of an MDU op
    mdu_start_E = 1;
    check("rb0"); tick();
    check("rb1"); tick();
    rst = 1;
    check("rb_rst"); chk("rb_flushF", {7'd0, flush_F}, 8'd1); chk("rb_stallE", {7'd0, stall_E}, 8'd0); tick();
    rst = 0; mdu_start_E = 0;
    check("rb_rel"); chk("rb_idle_stall", {7'd0, stall_F}, 8'd0); chk("rb_idle_busy", {7'd0, mdu_busy}, 8'd0); tick();

    // Random traffic with small register numbers to provoke matches
    for (int n = 0; n < 600; n++) begin
      rs_D = REG_AW'($urandom_range(0, 3)); rt_D = REG_AW'($urandom_range(0, 3));
      rs_E = REG_AW'($urandom_range(0, 3)); rt_E = REG_AW'($urandom_range(0, 3));
      wreg_E = REG_AW'($urandom_range(0, 3)); wreg_M = REG_AW'($urandom_range(0, 3));
      wreg_W = REG_AW'($urandom_range(0, 3));
      branch2_D = ($urandom_range(0, 3) == 0); branch1_D = ($urandom_range(0, 5) == 0);
      jr_D = ($urandom_range(0, 5) == 0);
      regwrite_E = $urandom_range(0, 1); memread_E = ($urandom_range(0, 3) == 0);
      regwrite_M = $urandom_range(0, 1); memread_M = ($urandom_range(0, 3) == 0);
      regwrite_W = $urandom_range(0, 1);
      except_M = ($urandom_range(0, 24) == 0);
      rst = ($urandom_range(0, 49) == 0);
      mdu_start_E = m_active ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 5) == 0);
      check("rnd");
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
